// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the fetch stage -- redirect source select,
// fetch FSM states and the sequential PC increment.
package cpu_pkg;

    // Redirect source select driven by ID; PC_SEL_RSV means "no redirect".
    typedef enum logic [1:0] {
        PC_SEL_BRA = 2'd0,
        PC_SEL_JAL = 2'd1,
        PC_SEL_JAR = 2'd2,
        PC_SEL_RSV = 2'd3
    } pc_sel_e;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } if_state_e;

    // Sequential fetch step in bytes.
    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next fetch address. Priority: trap, then redirect (target
// selected by pc_sel, low two bits cleared), then sequential +4 (wrapping),
// otherwise hold. pc_sel == PC_SEL_RSV never counts as a redirect.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = 'h100
) (
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  advance,
    input  logic                  redirect,
    input  logic [1:0]            pc_sel,
    input  logic [ADDR_WIDTH-1:0] bra_addr,
    input  logic [ADDR_WIDTH-1:0] jal_addr,
    input  logic [ADDR_WIDTH-1:0] jar_addr,
    input  logic                  trap,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  redirect_taken
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));

    logic [ADDR_WIDTH-1:0] target;

    // Pick the redirect target and decide the next fetch address.
    always_comb begin
        target         = '0;
        redirect_taken = trap | (redirect & (pc_sel != PC_SEL_RSV));
        case (pc_sel_e'(pc_sel))
            PC_SEL_BRA: target = bra_addr;
            PC_SEL_JAL: target = jal_addr;
            PC_SEL_JAR: target = jar_addr;
            default:    target = fetch_pc;
        endcase
        if (trap) begin
            target = TRAP_VECTOR;
        end
        next_pc = fetch_pc;
        if (redirect_taken) begin
            next_pc = target & ALIGN_MASK;
        end else if (advance) begin
            next_pc = fetch_pc + ADDR_WIDTH'(PC_INC);
        end
    end

endmodule

// File: rtl/stage_if.sv
// stage_if: instruction fetch stage. One request outstanding at most.
// Optional trap support is enabled with the STAGE_IF_TRAP_EN macro: the
// interrupt input then redirects to TRAP_VECTOR and records epc.
//
// Handshake: imem_req_valid rises in REQ and, with imem_req_addr, holds
// until imem_req_ready is seen high at a rising edge (a redirect in REQ may
// retarget a not-yet-accepted request). The memory returns exactly one
// imem_rsp_valid pulse per accepted request; responses seen outside WAIT
// are ignored. inst_valid towards ID is consumed on any edge with stall=0.
module stage_if
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    INST_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = 'h100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [1:0]            pc_sel,
    input  logic [ADDR_WIDTH-1:0] bra_addr,
    input  logic [ADDR_WIDTH-1:0] jal_addr,
    input  logic [ADDR_WIDTH-1:0] jar_addr,
    input  logic                  interrupt,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst_word,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc4,
    output logic [ADDR_WIDTH-1:0] epc
);

    // FSM state is kept in state_q for probing.
    if_state_e             state_q, state_d;
    logic                  kill_q, kill_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, next_pc;
    logic                  advance, capture, redirect_taken, trap;

`ifdef STAGE_IF_TRAP_EN
    assign trap = interrupt;
`else
    logic unused_interrupt;
    assign unused_interrupt = interrupt;
    assign trap             = 1'b0;
`endif

    pc_next_sel #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_pc_next_sel (
        .fetch_pc       (fetch_pc_q),
        .advance        (advance),
        .redirect       (redirect),
        .pc_sel         (pc_sel),
        .bra_addr       (bra_addr),
        .jal_addr       (jal_addr),
        .jar_addr       (jar_addr),
        .trap           (trap),
        .next_pc        (next_pc),
        .redirect_taken (redirect_taken)
    );

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = fetch_pc_q;

    // Next-state logic; a redirect overrides stall and kills any response
    // still owed to the old path.
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        advance = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                    kill_d  = redirect_taken;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    kill_d = 1'b0;
                    if (kill_q || redirect_taken) begin
                        state_d = REQ;
                    end else begin
                        capture = 1'b1;
                        advance = 1'b1;
                        state_d = stall ? HOLD : REQ;
                    end
                end else if (redirect_taken) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_taken || !stall) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, kill flag and fetch address registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            kill_q     <= 1'b0;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            fetch_pc_q <= next_pc;
        end
    end

    // Instruction output register towards ID.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_valid <= 1'b0;
            inst_word  <= '0;
            pc         <= '0;
            pc4        <= '0;
        end else if (capture) begin
            inst_valid <= 1'b1;
            inst_word  <= imem_rsp_data;
            pc         <= fetch_pc_q;
            pc4        <= fetch_pc_q + ADDR_WIDTH'(PC_INC);
        end else if (redirect_taken || !stall) begin
            inst_valid <= 1'b0;
        end
    end

`ifdef STAGE_IF_TRAP_EN
    // Record the fetch address abandoned by a trap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc <= '0;
        end else if (trap) begin
            epc <= fetch_pc_q;
        end
    end
`else
    assign epc = '0;
`endif

endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: directed scoreboard bench for stage_if. Expected requests and
// instructions are queued by the stimulus; a monitor pops and compares them.
module tb_stage_if;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [1:0]  pc_sel = 2'd0;
    logic [63:0] bra_addr = '0;
    logic [63:0] jal_addr = '0;
    logic [63:0] jar_addr = '0;
    logic        interrupt = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic [31:0] inst_word;
    logic [63:0] pc;
    logic [63:0] pc4;
    logic [63:0] epc;

    logic [63:0]  exp_req_q[$];
    logic [127:0] exp_inst_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int rsp_lat  = 1;

    logic [63:0] exp_target;
    logic [63:0] exp_epc;

    stage_if dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .pc_sel         (pc_sel),
        .bra_addr       (bra_addr),
        .jal_addr       (jal_addr),
        .jar_addr       (jar_addr),
        .interrupt      (interrupt),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_word      (inst_word),
        .pc             (pc),
        .pc4            (pc4),
        .epc            (epc)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'h1300_0000 ^ a[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_inst(input logic [63:0] p, input logic [63:0] p4);
        exp_inst_q.push_back({p, p4});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [63:0] a);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready && imem_req_addr == a) found = 1'b1;
        end
        n_checks++;
        if (found) n_pass++;
        else $display("FAIL wait_req: no accepted request at 0x%0h within 100 cycles, expected one", a);
    endtask

    task automatic check_reset();
        check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        check("rst_req_addr", imem_req_addr, 64'd0);
        check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_inst_word", {32'd0, inst_word}, 64'd0);
        check("rst_pc", pc, 64'd0);
        check("rst_pc4", pc4, 64'd0);
        check("rst_epc", epc, 64'd0);
    endtask

    // ---------------- memory responder (configurable latency) ----------------
    always begin : responder
        static bit          pend = 1'b0;
        static int          cnt = 0;
        static logic [63:0] paddr = '0;
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            pend  = 1'b1;
            cnt   = rsp_lat;
            paddr = imem_req_addr;
        end
        @(posedge clk);
        #1;
        if (pend && cnt <= 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(paddr);
            pend           = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            if (pend) cnt--;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always begin : monitor
        static bit           prev_v = 1'b0;
        static bit           prev_stall = 1'b0;
        static logic [63:0]  ea;
        static logic [127:0] ei;
        @(negedge clk);
        if (reset) begin
            if (imem_req_valid && imem_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL req_unexpected: got request 0x%0h, expected none", imem_req_addr);
                end else begin
                    ea = exp_req_q.pop_front();
                    check("req_addr", imem_req_addr, ea);
                end
            end else if (imem_req_valid && exp_req_q.size() != 0) begin
                check("req_stable", imem_req_addr, exp_req_q[0]);
            end
            if (inst_valid && (!prev_v || !prev_stall)) begin
                if (exp_inst_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL inst_unexpected: got inst pc 0x%0h, expected none", pc);
                end else begin
                    ei = exp_inst_q.pop_front();
                    check("inst_pc", pc, ei[127:64]);
                    check("inst_pc4", pc4, ei[63:0]);
                    check("inst_word", {32'd0, inst_word}, {32'd0, mem_word(ei[127:64])});
                end
            end
            prev_v     = inst_valid;
            prev_stall = stall;
        end else begin
            prev_v     = 1'b0;
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
`ifdef STAGE_IF_TRAP_EN
        exp_target = 64'h100;
        exp_epc    = 64'h40;
`else
        exp_target = 64'h80;
        exp_epc    = 64'h0;
`endif
        #3;
        check_reset();

        // Sequential fetch from reset; stall while holding the 0x4 instruction.
        exp_req_q.push_back(64'h0);
        exp_req_q.push_back(64'h4);
        exp_req_q.push_back(64'h8);
        push_inst(64'h0, 64'h4);
        push_inst(64'h4, 64'h8);
        push_inst(64'h8, 64'hC);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        wait_req(64'h4);
        tick();
        stall = 1'b1;
        repeat (5) begin
            tick();
            check("hold_pc", pc, 64'h4);
            check("hold_inst_valid", {63'd0, inst_valid}, 64'd1);
            check("hold_req_valid", {63'd0, imem_req_valid}, 64'd0);
        end
        stall = 1'b0;

        // Memory not ready for three REQ cycles at 0x8.
        imem_req_ready = 1'b0;
        repeat (4) tick();
        imem_req_ready = 1'b1;
        wait_req(64'h8);
        tick();
        imem_req_ready = 1'b0;
        repeat (3) tick();

        // Redirect (jal 0x203) while waiting on 0x10 with a slow response.
        rsp_lat = 2;
        exp_req_q.push_back(64'hC);
        exp_req_q.push_back(64'h10);
        exp_req_q.push_back(64'h200);
        push_inst(64'hC, 64'h10);
        push_inst(64'h200, 64'h204);
        imem_req_ready = 1'b1;
        wait_req(64'h10);
        tick();
        redirect = 1'b1;
        pc_sel   = 2'd1;
        jal_addr = 64'h203;
        tick();
        redirect = 1'b0;
        wait_req(64'h200);
        tick();
        imem_req_ready = 1'b0;
        repeat (4) tick();

        // pc_sel=3 ignored; then branch to the top of the address space.
        rsp_lat  = 1;
        redirect = 1'b1;
        pc_sel   = 2'd3;
        bra_addr = 64'h400;
        tick();
        redirect = 1'b0;
        tick();
        check("rsv_sel_addr", imem_req_addr, 64'h204);
        redirect = 1'b1;
        pc_sel   = 2'd0;
        bra_addr = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        redirect = 1'b0;
        exp_req_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_req_q.push_back(64'h0);
        push_inst(64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
        push_inst(64'h0, 64'h4);
        imem_req_ready = 1'b1;
        wait_req(64'h0);
        tick();
        imem_req_ready = 1'b0;
        repeat (3) tick();

        // Jump to 0x40, then interrupt + redirect + stall coincident with response.
        redirect = 1'b1;
        pc_sel   = 2'd2;
        jar_addr = 64'h41;
        tick();
        redirect = 1'b0;
        exp_req_q.push_back(64'h40);
        exp_req_q.push_back(exp_target);
        push_inst(exp_target, exp_target + 64'h4);
        imem_req_ready = 1'b1;
        wait_req(64'h40);
        tick();
        redirect  = 1'b1;
        pc_sel    = 2'd2;
        jar_addr  = 64'h80;
        interrupt = 1'b1;
        stall     = 1'b1;
        tick();
        redirect  = 1'b0;
        interrupt = 1'b0;
        stall     = 1'b0;
        check("epc", epc, exp_epc);
        wait_req(exp_target);
        tick();
        imem_req_ready = 1'b0;
        repeat (4) tick();

        // Reset in the middle of a slow fetch; the late response is ignored.
        rsp_lat = 3;
        exp_req_q.push_back(exp_target + 64'h4);
        imem_req_ready = 1'b1;
        wait_req(exp_target + 64'h4);
        tick();
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        check_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) tick();
        rsp_lat = 1;
        exp_req_q.push_back(64'h0);
        push_inst(64'h0, 64'h4);
        imem_req_ready = 1'b1;
        wait_req(64'h0);
        tick();
        imem_req_ready = 1'b0;
        repeat (5) tick();

        check("req_q_empty", 64'(exp_req_q.size()), 64'd0);
        check("inst_q_empty", 64'(exp_inst_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stage_if.md
STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
  ADDR_WIDTH  64  PC/address width
  INST_WIDTH  32  instruction width
  RESET_PC  0  first fetch address
  TRAP_VECTOR  'h100  interrupt target (used only with STAGE_IF_TRAP_EN)
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
  clk  in  1  single clock, all state on rising edge
  reset  in  1  asynchronous, active-low reset
  stall  in  1  ID cannot accept a new instruction
  redirect  in  1  control-flow change this cycle
  pc_sel  in  2  redirect source: 0 bra_addr, 1 jal_addr, 2 jar_addr, 3 reserved
  bra_addr / jal_addr / jar_addr  in  ADDR_WIDTH each  redirect targets from ID
  interrupt  in  1  trap request (macro-gated)
  imem_req_valid  out  1  fetch request valid
  imem_req_ready  in  1  memory accepts request
  imem_req_addr  out  ADDR_WIDTH  fetch address
  imem_rsp_valid  in  1  fetch data returned
  imem_rsp_data  in  INST_WIDTH  fetched word
  inst_valid  out  1  inst_word/pc/pc4 valid for ID
  inst_word  out  INST_WIDTH  fetched instruction
  pc  out  ADDR_WIDTH  address of inst_word
  pc4  out  ADDR_WIDTH  pc+4
  epc  out  ADDR_WIDTH  interrupted fetch address (macro-gated)

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, HOLD; IDLE->REQ unconditionally one cycle after reset release.
REQ-004 In REQ, imem_req_valid=1, imem_req_addr=fetch_pc; valid&ready -> WAIT; the request SHALL stay stable until accepted.
REQ-005 At most one request SHALL be outstanding; imem_req_valid=0 in WAIT and HOLD.
REQ-006 In WAIT, on imem_rsp_valid with no pending kill: register inst_word=rsp_data, pc=fetch_pc, pc4=fetch_pc+4, inst_valid=1 next cycle; fetch_pc<=fetch_pc+4; stall=0 -> REQ, stall=1 -> HOLD.
REQ-007 HOLD SHALL keep inst_word/pc/pc4/inst_valid unchanged; stall falling -> REQ.
REQ-008 inst_valid SHALL drop to 0 the cycle after ID consumes (stall=0) unless a new response lands that cycle.
REQ-009 Steady state with ready=1 and 1-cycle response: one instruction per 2 cycles.
REQ-010 Redirect with pc_sel 0..2: fetch_pc<=selected target with bits [1:0] forced 0; inst_valid<=0 next cycle; FSM -> REQ (or from REQ, the unaccepted request is retargeted next cycle).
REQ-011 Redirect in WAIT before the response SHALL set kill; the killed response is discarded, then -> REQ. Redirect coincident with the response SHALL discard that response.
REQ-012 Redirect SHALL take priority over stall; pc_sel=3 SHALL ignore redirect.
REQ-013 pc4 and fetch_pc increment SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-014 reset low SHALL immediately force: state IDLE, fetch_pc=RESET_PC, kill=0, inst_valid=0, imem_req_valid=0, inst_word=0, pc=0, pc4=0, epc=0.
REQ-015 Reset mid-WAIT SHALL drop the outstanding fetch; a response arriving after release while in IDLE/REQ SHALL be ignored.

Configuration
REQ-016 With STAGE_IF_TRAP_EN defined: interrupt=1 SHALL act as a redirect to TRAP_VECTOR with priority over redirect, capturing epc<=fetch_pc (the discarded address).
REQ-017 Without STAGE_IF_TRAP_EN: interrupt SHALL be ignored and epc held at 0.

Structure
REQ-018 Package cpu_pkg SHALL hold the pc_sel encoding enum, the FSM state enum, and the +4 increment constant.
REQ-019 One sub-module, pc_next_sel, SHALL compute the next fetch_pc (increment, target select, alignment, trap); the FSM stays in stage_if.

Verification
REQ-020 Reset release, ready=1, rsp 1 cycle later: requests at 0x0, 0x4, 0x8; inst_valid pulses with pc=0x0, pc4=0x4 first.
REQ-021 stall=1 for 5 cycles after the response at 0x4: no new request, outputs held at pc=0x4; stall drops -> request 0x8.
REQ-022 redirect, pc_sel=1, jal_addr=0x203 during WAIT at 0x10: response discarded, next request 0x200, no inst_valid for 0x10.
REQ-023 imem_req_ready=0 for 3 cycles: address stable at 0x8; accepted on 4th cycle; exactly one response consumed.
REQ-024 fetch_pc=0xFFFF_FFFF_FFFF_FFFC: pc4=0x0, next request 0x0.
REQ-025 STAGE_IF_TRAP_EN, interrupt with redirect at fetch_pc 0x40: next request 0x100, epc=0x40; macro off: request proceeds at the redirect target, epc=0.
